// File: rtl/mem_port_arbiter_pkg.sv
// Shared FSM encoding, grant identifiers and default widths for the
// IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/arb_perf_cnt.sv
// Saturating event counter used for the arbiter's optional performance
// statistics; sticks at all-ones instead of wrapping.
module arb_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks for the memory port arbiter: a data request must stay
// asserted for the whole life of its memory transaction.
module mem_port_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic d_busy,
    input logic d_req
);

    a_d_req_held: assert property (@(posedge clk) disable iff (rst) d_busy |-> d_req);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Optional statistics counters are enabled with `define MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_done_o,
    output logic              d_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       if_stall_cnt_o,
    output logic [31:0]       d_stall_cnt_o,
    output logic [31:0]       kill_cnt_o,
`endif
    input  logic              mem_ack_i
);

    arb_state_e        state_r, state_next_s;
    logic              last_grant_r;
    logic              kill_pend_r;
    logic              grant_d_s, grant_if_s, ack_s, kill_s;
    logic              mem_req_r, mem_we_r, if_done_r, d_done_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r, if_rdata_r, d_rdata_r;

    // A kill seen on the ack cycle itself suppresses the fetch as well.
    assign kill_s = kill_pend_r | if_kill_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant decision and next-state logic; data wins ties unless it won last.
    always_comb begin
        state_next_s = state_r;
        grant_d_s    = 1'b0;
        grant_if_s   = 1'b0;
        ack_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req_i && (!if_req_i || (last_grant_r == GNT_IF))) begin
                    grant_d_s    = 1'b1;
                    state_next_s = DBUSY;
                end else if (if_req_i) begin
                    grant_if_s   = 1'b1;
                    state_next_s = IBUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ack_i) begin
                    ack_s        = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = state_r;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Memory port, response registers and arbitration history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            if_rdata_r   <= '0;
            d_rdata_r    <= '0;
            if_done_r    <= 1'b0;
            d_done_r     <= 1'b0;
            last_grant_r <= GNT_IF;
            kill_pend_r  <= 1'b0;
        end else begin
            if_done_r <= 1'b0;
            d_done_r  <= 1'b0;
            if (grant_d_s) begin
                mem_req_r    <= 1'b1;
                mem_we_r     <= d_we_i;
                mem_addr_r   <= d_addr_i;
                mem_wdata_r  <= d_wdata_i;
                last_grant_r <= GNT_D;
            end else if (grant_if_s) begin
                mem_req_r    <= 1'b1;
                mem_we_r     <= 1'b0;
                mem_addr_r   <= if_addr_i;
                mem_wdata_r  <= '0;
                last_grant_r <= GNT_IF;
            end else if (ack_s) begin
                mem_req_r <= 1'b0;
                mem_we_r  <= 1'b0;
                if (state_r == DBUSY) begin
                    d_rdata_r <= mem_rdata_i;
                    d_done_r  <= 1'b1;
                end else begin
                    if_rdata_r <= mem_rdata_i;
                    if_done_r  <= ~kill_s;
                end
            end
            if ((state_r == IBUSY) && if_kill_i) begin
                kill_pend_r <= 1'b1;
            end else if (state_r == RESP) begin
                kill_pend_r <= 1'b0;
            end
        end
    end

    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign if_rdata_o  = if_rdata_r;
    assign d_rdata_o   = d_rdata_r;
    assign if_done_o   = if_done_r;
    assign d_done_o    = d_done_r;
    assign if_stall_o  = if_req_i & ~if_done_r;
    assign d_stall_o   = d_req_i & ~d_done_r;

`ifdef MEM_ARB_PERF_EN
    logic kill_evt_s;
    assign kill_evt_s = ack_s & (state_r == IBUSY) & kill_s;

    arb_perf_cnt #(.W(32)) u_if_stall_cnt (
        .clk(clk_i), .rst(rst_i), .inc(if_stall_o), .cnt(if_stall_cnt_o)
    );
    arb_perf_cnt #(.W(32)) u_d_stall_cnt (
        .clk(clk_i), .rst(rst_i), .inc(d_stall_o), .cnt(d_stall_cnt_o)
    );
    arb_perf_cnt #(.W(32)) u_kill_cnt (
        .clk(clk_i), .rst(rst_i), .inc(kill_evt_s), .cnt(kill_cnt_o)
    );
`endif

    mem_port_arbiter_chk u_chk (
        .clk    (clk_i),
        .rst    (rst_i),
        .d_busy (state_r == DBUSY),
        .d_req  (d_req_i)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference
// model of grants, memory handshakes and completion pulses.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk, rst;
    logic        if_req_i, if_kill_i, if_done_o, if_stall_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        d_req_i, d_we_i, d_done_o, d_stall_o;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] if_stall_cnt_o, d_stall_cnt_o, kill_cnt_o;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_rdata_o(if_rdata_o), .if_done_o(if_done_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
`ifdef MEM_ARB_PERF_EN
        .if_stall_cnt_o(if_stall_cnt_o), .d_stall_cnt_o(d_stall_cnt_o), .kill_cnt_o(kill_cnt_o),
`endif
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    int checks, errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: the transaction in flight and the completion due next.
    bit          m_busy, m_side, m_kill, m_bubble, m_last, m_we, m_d_store;
    bit          m_if_done, m_d_done;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    int          m_kills, m_if_stalls, m_d_stalls;
    bit          if_pend, d_pend;
    int          wait_cnt, ack_dly;

    task automatic model_reset();
        m_busy = 1'b0; m_bubble = 1'b0; m_kill = 1'b0; m_last = GNT_IF;
        m_if_done = 1'b0; m_d_done = 1'b0; m_we = 1'b0; m_d_store = 1'b0;
        m_kills = 0; m_if_stalls = 0; m_d_stalls = 0;
        if_pend = 1'b0; d_pend = 1'b0; wait_cnt = 0; ack_dly = 0;
    endtask

    task automatic check_outputs();
        check_eq("mem_req", 32'(mem_req_o), 32'(m_busy));
        if (m_busy) begin
            check_eq("mem_addr", mem_addr_o, m_addr);
            check_eq("mem_we", 32'(mem_we_o), 32'(m_we));
            if (m_we) check_eq("mem_wdata", mem_wdata_o, m_wdata);
        end
        check_eq("if_done", 32'(if_done_o), 32'(m_if_done));
        if (m_if_done) check_eq("if_rdata", if_rdata_o, m_if_rdata);
        check_eq("d_done", 32'(d_done_o), 32'(m_d_done));
        if (m_d_done && !m_d_store) check_eq("d_rdata", d_rdata_o, m_d_rdata);
        check_eq("if_stall", 32'(if_stall_o), 32'(if_req_i & ~m_if_done));
        check_eq("d_stall", 32'(d_stall_o), 32'(d_req_i & ~m_d_done));
`ifdef MEM_ARB_PERF_EN
        check_eq("if_stall_cnt", if_stall_cnt_o, 32'(m_if_stalls));
        check_eq("d_stall_cnt", d_stall_cnt_o, 32'(m_d_stalls));
        check_eq("kill_cnt", kill_cnt_o, 32'(m_kills));
`endif
    endtask

    // One clock: check, let the agents react, then advance the model.
    task automatic step();
        bit          ack;
        logic [31:0] rd;
        @(negedge clk);
        check_outputs();
        if (m_if_done) if_pend = 1'b0;
        if (m_d_done) d_pend = 1'b0;
        if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if_kill_i = 1'b0;
        if (if_pend && $urandom_range(0, 9) == 0) begin
            if_kill_i = 1'b1;
            if_pend = 1'b0;
        end
        if_req_i = if_pend;
        if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1'b1;
            d_we_i = 1'($urandom_range(0, 1));
            d_addr_i = $urandom & 32'hFFFF_FFFC;
            d_wdata_i = $urandom;
        end
        d_req_i = d_pend;
        ack = 1'b0;
        rd = $urandom;
        if (m_busy) begin
            if (wait_cnt >= ack_dly) ack = 1'b1;
            else wait_cnt++;
        end else if ($urandom_range(0, 15) == 0) begin
            ack = 1'b1;
        end
        mem_ack_i = ack;
        mem_rdata_i = rd;

        if (if_req_i && !m_if_done) m_if_stalls++;
        if (d_req_i && !m_d_done) m_d_stalls++;
        m_if_done = 1'b0;
        m_d_done = 1'b0;
        if (m_busy) begin
            if (if_kill_i && m_side == GNT_IF) m_kill = 1'b1;
            if (ack) begin
                m_busy = 1'b0;
                m_bubble = 1'b1;
                if (m_side == GNT_D) begin
                    m_d_done = 1'b1;
                    m_d_store = m_we;
                    if (!m_we) m_d_rdata = rd;
                end else begin
                    m_if_rdata = rd;
                    m_if_done = !m_kill;
                    if (m_kill) m_kills++;
                end
                m_we = 1'b0;
            end
        end else if (m_bubble) begin
            m_bubble = 1'b0;
            m_kill = 1'b0;
        end else if (d_req_i || if_req_i) begin
            m_side = (d_req_i && if_req_i) ? ~m_last : d_req_i;
            m_last = m_side;
            m_busy = 1'b1;
            wait_cnt = 0;
            ack_dly = $urandom_range(0, 3);
            if (m_side == GNT_D) begin
                m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i;
            end else begin
                m_addr = if_addr_i; m_we = 1'b0;
            end
        end
    endtask

    initial begin
        bit found;
        clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
        if_req_i = 1'b0; if_kill_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_mem_req", 32'(mem_req_o), 32'h0);
        check_eq("rst_mem_we", 32'(mem_we_o), 32'h0);
        check_eq("rst_mem_addr", mem_addr_o, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata_o, 32'h0);
        check_eq("rst_if_done", 32'(if_done_o), 32'h0);
        check_eq("rst_d_done", 32'(d_done_o), 32'h0);
        check_eq("rst_if_rdata", if_rdata_o, 32'h0);
        check_eq("rst_d_rdata", d_rdata_o, 32'h0);
        rst = 1'b0;

        // First contention after reset: a load at 0x100 against a fetch.
        if_pend = 1'b1; if_addr_i = 32'h0000_0040;
        d_pend = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0100; d_wdata_i = '0;
        for (int i = 0; i < 3000; i++) step();

        // Reset in the middle of a data transaction.
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step();
            if (m_busy && m_side == GNT_D) found = 1'b1;
        end
        check_eq("find_dbusy", 32'(found), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_mem_req", 32'(mem_req_o), 32'h0);
        check_eq("async_rst_d_done", 32'(d_done_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        if_req_i = 1'b0; d_req_i = 1'b0; if_kill_i = 1'b0;
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check_eq("late_ack_d_done", 32'(d_done_o), 32'h0);
        check_eq("late_ack_if_done", 32'(if_done_o), 32'h0);
        check_eq("late_ack_mem_req", 32'(mem_req_o), 32'h0);
        @(negedge clk);
        check_eq("late_ack_d_done2", 32'(d_done_o), 32'h0);
        check_eq("late_ack_mem_req2", 32'(mem_req_o), 32'h0);

`ifdef MEM_ARB_PERF_EN
        force dut.u_if_stall_cnt.cnt_r = 32'hFFFF_FFFE;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        @(negedge clk);
        release dut.u_if_stall_cnt.cnt_r;
        repeat (3) @(negedge clk);
        check_eq("if_stall_cnt_sat", if_stall_cnt_o, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
